// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM arbiter.
package ram_arb_pkg;

   typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} arb_state_t;
   typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_t;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 32;

endpackage

// File: rtl/arb_starve_ctr.sv
// Port-1 starvation guard: counts consecutive denied port-1 request cycles
// and raises force_grant once the count reaches STARVE_LIMIT.
module arb_starve_ctr
   import ram_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic p1_req,
   input  logic p1_gnt,
   output logic force_grant
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt_q, starve_cnt_d;
   arb_state_t state_q, state_d;

   // Force takes effect in the same cycle the count hits the limit; a dropped request cancels it.
   always_comb begin
      force_grant = p1_req && ((state_q == FORCE) || (starve_cnt_q == LIMIT));
   end

   // Next count and next state: clear on grant or idle, saturate at the limit.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!p1_req || p1_gnt) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != LIMIT) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
      // FORCE is only held across an edge if the forced grant has not happened yet.
      state_d = NORMAL;
      if (force_grant && !p1_gnt) begin
         state_d = FORCE;
      end
   end

   // Counter and force-state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_q <= '0;
         state_q      <= NORMAL;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         state_q      <= state_d;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port data RAM. Port 0 (CPU) has fixed
// priority; port 1 is forced through after STARVE_LIMIT denied cycles.
// Read data returns one cycle after the grant. Optional grant/force
// performance counters are built when RAM_ARB_PERF_EN is defined.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW           = AW_DEF,
   parameter int DW           = DW_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic          p0_gnt,
   output logic          p0_rvalid,
   output logic [DW-1:0] p0_rdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic          p1_gnt,
   output logic          p1_rvalid,
   output logic [DW-1:0] p1_rdata,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
`ifdef RAM_ARB_PERF_EN
   ,
   input  logic          perf_clr,
   output logic [15:0]   p0_gnt_cnt,
   output logic [15:0]   p1_gnt_cnt,
   output logic [15:0]   force_cnt
`endif
);

   logic  force_grant;
   logic  rd_pend_q, rd_pend_d;
   port_t rd_port_q, rd_port_d;

   arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk         (clk),
      .rst         (rst),
      .p1_req      (p1_req),
      .p1_gnt      (p1_gnt),
      .force_grant (force_grant)
   );

   // Combinational grant; held low during reset so every output is quiet.
   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (rst) begin
         if (p1_req && (force_grant || !p0_req)) begin
            p1_gnt = 1'b1;
         end else if (p0_req) begin
            p0_gnt = 1'b1;
         end
      end
   end

   // RAM bus mux from the granted port; all zero when nobody is granted.
   always_comb begin
      ram_en    = p0_gnt | p1_gnt;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (p0_gnt) begin
         ram_we    = p0_we;
         ram_addr  = p0_addr;
         ram_wdata = p0_wdata;
      end else if (p1_gnt) begin
         ram_we    = p1_we;
         ram_addr  = p1_addr;
         ram_wdata = p1_wdata;
      end
   end

   // Track which port owns the read data arriving next cycle.
   always_comb begin
      rd_pend_d = ram_en && !ram_we;
      rd_port_d = rd_port_q;
      if (rd_pend_d) begin
         rd_port_d = p1_gnt ? PORT1 : PORT0;
      end
   end

   // Read-return registers; reset drops any read in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pend_q <= 1'b0;
         rd_port_q <= PORT0;
      end else begin
         rd_pend_q <= rd_pend_d;
         rd_port_q <= rd_port_d;
      end
   end

   // Route returning RAM data to its owner; the other port sees zero.
   always_comb begin
      p0_rvalid = rd_pend_q && (rd_port_q == PORT0);
      p1_rvalid = rd_pend_q && (rd_port_q == PORT1);
      p0_rdata  = p0_rvalid ? ram_rdata : '0;
      p1_rdata  = p1_rvalid ? ram_rdata : '0;
   end

`ifdef RAM_ARB_PERF_EN
   logic [15:0] p0_gnt_cnt_q, p0_gnt_cnt_d;
   logic [15:0] p1_gnt_cnt_q, p1_gnt_cnt_d;
   logic [15:0] force_cnt_q, force_cnt_d;

   // Wrapping event counters; a clear wins over any increment in the same cycle.
   always_comb begin
      p0_gnt_cnt_d = p0_gnt_cnt_q + {15'd0, p0_gnt};
      p1_gnt_cnt_d = p1_gnt_cnt_q + {15'd0, p1_gnt};
      force_cnt_d  = force_cnt_q + {15'd0, (force_grant && p1_gnt)};
      if (perf_clr) begin
         p0_gnt_cnt_d = '0;
         p1_gnt_cnt_d = '0;
         force_cnt_d  = '0;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p0_gnt_cnt_q <= '0;
         p1_gnt_cnt_q <= '0;
         force_cnt_q  <= '0;
      end else begin
         p0_gnt_cnt_q <= p0_gnt_cnt_d;
         p1_gnt_cnt_q <= p1_gnt_cnt_d;
         force_cnt_q  <= force_cnt_d;
      end
   end

   assign p0_gnt_cnt = p0_gnt_cnt_q;
   assign p1_gnt_cnt = p1_gnt_cnt_q;
   assign force_cnt  = force_cnt_q;
`endif

endmodule
